connect4_turn_ctrl: RTL and testbench
=====================================

CONNECT4_TURN_CTRL -- requirements
Module: connect4_turn_ctrl

Interface
REQ-001 SHALL have parameter NUM_COLS, default 7, number of board columns (legal columns 0..NUM_COLS-1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000000, turn-timer limit in clk cycles.
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports human_col in 3 and human_valid in 1: one-cycle human move request.
REQ-006 SHALL have port ai_mode  in  1  player 1 is driven by the AI when high.
REQ-007 SHALL have ports ai_req out 1, ai_col in 3 and ai_valid in 1: AI move handshake.
REQ-008 SHALL have port col_full  in  NUM_COLS  per-column full flag from the board.
REQ-009 SHALL have ports drop_valid out 1, drop_col out 3, drop_player out 1 and drop_ready in 1: drop command to the board.
REQ-010 SHALL have ports chk_start out 1, chk_done in 1, chk_win in 1 and chk_draw in 1: win/draw checker handshake.
REQ-011 SHALL have ports new_game in 1, player out 1, game_over out 1, winner out 2 (00 none, 01 P0, 10 P1, 11 draw), moves out 6, illegal out 1 and timeout out 1.

Function
REQ-012 SHALL implement states TURN, ISSUE, CHECK and OVER; game_over SHALL be high only in OVER.
REQ-013 In TURN with player==1 and ai_mode==1, ai_req SHALL be high; only ai_valid/ai_col SHALL be sampled, and human_valid SHALL be ignored.
REQ-014 In TURN otherwise, only human_valid/human_col SHALL be sampled; ai_req SHALL be low and ai_valid SHALL be ignored.
REQ-015 A sampled column SHALL be legal iff col<NUM_COLS and col_full[col]==0.
REQ-016 An illegal column SHALL pulse illegal for exactly one cycle on the next cycle and SHALL keep the state in TURN.
REQ-017 A legal request in cycle N SHALL latch the column, enter ISSUE, and assert drop_valid in cycle N+1.
REQ-018 In ISSUE, drop_valid, drop_col and drop_player(=player) SHALL be held stable until a cycle with drop_ready high; that cycle completes the transfer.
REQ-019 On transfer, moves SHALL increment, saturating at 42; the FSM SHALL enter CHECK and pulse chk_start for exactly one cycle on the first CHECK cycle.
REQ-020 In CHECK, the FSM SHALL wait for chk_done; chk_win SHALL take priority over chk_draw.
REQ-021 On chk_win, the FSM SHALL go to OVER with winner=player+1; on chk_draw, it SHALL go to OVER with winner=11.
REQ-022 If neither chk_win nor chk_draw is set, player SHALL toggle and the FSM SHALL return to TURN.
REQ-023 In OVER, all move, AI and checker inputs SHALL be ignored.
REQ-024 new_game in any state SHALL, on the next cycle, give TURN, player=0, winner=00, moves=0, with drop_valid, chk_start and ai_req low; rst SHALL take priority over new_game.
REQ-025 drop_col SHALL be zero whenever drop_valid is low.

Reset
REQ-026 On rst: state=TURN, player=0, winner=00, moves=0, and game_over, drop_valid, drop_col, drop_player, chk_start, ai_req, illegal and timeout all 0; the turn timer SHALL be cleared.
REQ-027 rst asserted mid-ISSUE or mid-CHECK SHALL abort the operation with no transfer counted.

Configuration
REQ-028 With macro TURN_TIMEOUT_EN defined, a turn timer SHALL clear on every entry to TURN and increment each TURN cycle.
REQ-029 With TURN_TIMEOUT_EN defined, when the timer reaches TIMEOUT_CYCLES-1 with no legal request that cycle, the FSM SHALL select the lowest-indexed non-full column, pulse timeout for one cycle and proceed as in REQ-017.
REQ-030 With TURN_TIMEOUT_EN defined, a pending AI request SHALL be withdrawn on timeout.
REQ-031 With TURN_TIMEOUT_EN undefined, no timer SHALL exist and timeout SHALL be tied to 0; the port SHALL exist in both builds.

Verification
REQ-032 Bench SHALL cover: rst, then human_valid=1, human_col=3, col_full=0 -> drop_valid=1, drop_col=3, drop_player=0 next cycle; hold 2 cycles with drop_ready=1 on the 3rd -> chk_start one pulse, moves=1.
REQ-033 Bench SHALL cover: col_full=7'b0001000, human_col=3 -> illegal one-cycle pulse, state stays TURN; human_col=7 -> illegal.
REQ-034 Bench SHALL cover: ai_mode=1 on P1 turn -> ai_req=1; human_valid ignored; ai_valid=1, ai_col=5 -> drop_col=5, drop_player=1, ai_req=0.
REQ-035 Bench SHALL cover: chk_done=1 with chk_win=1 and chk_draw=1 on P0 move -> game_over=1, winner=01; later moves ignored; new_game -> player=0, winner=00, moves=0.
REQ-036 Bench SHALL cover: TURN_TIMEOUT_EN with TIMEOUT_CYCLES=16, col_full=7'b0000011, idle -> timeout pulse, drop_col=2.
REQ-037 Bench SHALL cover: rst during ISSUE -> all outputs at reset values next cycle, moves=0.

Source files
------------

// File: rtl/connect4_turn_ctrl.sv
// connect4_turn_ctrl: turn sequencer for a two-player Connect-4 board.
// It accepts a move from the human or the AI, drives the drop command to the
// board, runs the win/draw checker, then passes the turn or ends the game.
// Optional build macro: TURN_TIMEOUT_EN adds a per-turn timer. When the timer
// expires, the controller plays the lowest free column on the player's behalf.
module connect4_turn_ctrl #(
    parameter int NUM_COLS       = 7,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          human_col,
    input  logic                human_valid,
    input  logic                ai_mode,
    output logic                ai_req,
    input  logic [2:0]          ai_col,
    input  logic                ai_valid,
    input  logic [NUM_COLS-1:0] col_full,
    output logic                drop_valid,
    output logic [2:0]          drop_col,
    output logic                drop_player,
    input  logic                drop_ready,
    output logic                chk_start,
    input  logic                chk_done,
    input  logic                chk_win,
    input  logic                chk_draw,
    input  logic                new_game,
    output logic                player,
    output logic                game_over,
    output logic [1:0]          winner,
    output logic [5:0]          moves,
    output logic                illegal,
    output logic                timeout
);

    typedef enum logic [1:0] {TURN, ISSUE, CHECK, OVER} state_t;

    localparam logic [5:0] MAX_MOVES = 6'd42;

    state_t     state;
    state_t     state_next;
    logic [2:0] col_q;
    logic [7:0] full_ext;
    logic       ai_turn;
    logic       req_valid;
    logic [2:0] req_col;
    logic       req_legal;
    logic       force_move;
    logic [2:0] free_col;
    logic [2:0] col_next;
    logic       load_col;
    logic       illegal_next;
    logic       transfer;
    logic       toggle;
    logic       end_game;
    logic [1:0] winner_next;

    // Widen the full map to all eight encodable columns so that out-of-range columns read as full.
    always_comb begin
        full_ext = '1;
        for (int i = 0; i < NUM_COLS && i < 8; i++) full_ext[i] = col_full[i];
    end

    // Only the side whose turn it is gets sampled; the other source is ignored.
    assign ai_turn   = player & ai_mode;
    assign req_valid = ai_turn ? ai_valid : human_valid;
    assign req_col   = ai_turn ? ai_col : human_col;
    assign req_legal = ~full_ext[req_col];

    assign game_over   = (state == OVER);
    assign ai_req      = (state == TURN) & ai_turn;
    assign drop_valid  = (state == ISSUE);
    assign drop_col    = drop_valid ? col_q : 3'd0;
    assign drop_player = drop_valid & player;

`ifdef TURN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer;
    logic          timer_expired;
    logic          any_free;

    // Find the lowest-indexed non-full column, which becomes the forced move on timeout.
    always_comb begin
        any_free = 1'b0;
        free_col = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!full_ext[i]) begin
                any_free = 1'b1;
                free_col = 3'(i);
            end
        end
    end

    assign timer_expired = (state == TURN) && (timer == TW'(TIMEOUT_CYCLES - 1));
    // A legal request in the expiry cycle wins over the forced move.
    assign force_move    = timer_expired & any_free & ~(req_valid & req_legal);

    // Turn timer. It is held at zero outside TURN so that each entry to TURN starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst || new_game || state != TURN) timer <= '0;
        else if (!timer_expired)              timer <= timer + TW'(1);
    end

    // One-cycle timeout pulse, aligned with the first ISSUE cycle of the forced move.
    always_ff @(posedge clk) begin
        if (rst || new_game) timeout <= 1'b0;
        else                 timeout <= force_move;
    end
`else
    // Without the timer TIMEOUT_CYCLES has no effect. It is still referenced so both builds share one parameter list.
    assign force_move = 1'b0 && (TIMEOUT_CYCLES > 0);
    assign free_col   = 3'd0;
    assign timeout    = 1'b0;
`endif

    // Next-state decode and the per-cycle control strobes that drive the datapath.
    always_comb begin
        // NOTE: every signal written here is given a default first, so no path through the case infers a latch.
        state_next   = state;
        load_col     = 1'b0;
        col_next     = req_col;
        illegal_next = 1'b0;
        transfer     = 1'b0;
        toggle       = 1'b0;
        end_game     = 1'b0;
        winner_next  = 2'b00;
        unique case (state)
            TURN: begin
                if (req_valid && req_legal) begin
                    load_col   = 1'b1;
                    state_next = ISSUE;
                end else begin
                    illegal_next = req_valid;
                    if (force_move) begin
                        load_col   = 1'b1;
                        col_next   = free_col;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (drop_ready) begin
                    transfer   = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (chk_done) begin
                    if (chk_win) begin
                        end_game    = 1'b1;
                        winner_next = player ? 2'b10 : 2'b01;
                        state_next  = OVER;
                    end else if (chk_draw) begin
                        end_game    = 1'b1;
                        winner_next = 2'b11;
                        state_next  = OVER;
                    end else begin
                        toggle     = 1'b1;
                        state_next = TURN;
                    end
                end
            end
            OVER:    state_next = OVER;
            default: state_next = TURN;
        endcase
    end

    // State register and game datapath. rst and new_game restore the same start-of-game values.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here; rst is sampled at the clock edge like any other input.
        if (rst || new_game) begin
            // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
            state     <= TURN;
            player    <= 1'b0;
            winner    <= 2'b00;
            moves     <= 6'd0;
            col_q     <= 3'd0;
            chk_start <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_next;
            illegal   <= illegal_next;
            chk_start <= transfer;
            if (load_col)                       col_q  <= col_next;
            if (transfer && moves != MAX_MOVES) moves  <= moves + 6'd1;
            if (toggle)                         player <= ~player;
            if (end_game)                       winner <= winner_next;
        end
    end

endmodule

// File: tb/tb_connect4_turn_ctrl.sv
// Testbench for connect4_turn_ctrl. It runs directed scenarios, then random
// games checked against a game-level model: whose turn it is, the move count
// and the winner, all derived from the game rules.
module tb_connect4_turn_ctrl;

    localparam int NUM_COLS       = 7;
    localparam int TIMEOUT_CYCLES = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [2:0]          human_col;
    logic                human_valid;
    logic                ai_mode;
    logic                ai_req;
    logic [2:0]          ai_col;
    logic                ai_valid;
    logic [NUM_COLS-1:0] col_full;
    logic                drop_valid;
    logic [2:0]          drop_col;
    logic                drop_player;
    logic                drop_ready;
    logic                chk_start;
    logic                chk_done;
    logic                chk_win;
    logic                chk_draw;
    logic                new_game;
    logic                player;
    logic                game_over;
    logic [1:0]          winner;
    logic [5:0]          moves;
    logic                illegal;
    logic                timeout;

    int total = 0;
    int bad   = 0;

    connect4_turn_ctrl #(.NUM_COLS(NUM_COLS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .human_col(human_col), .human_valid(human_valid),
        .ai_mode(ai_mode), .ai_req(ai_req), .ai_col(ai_col), .ai_valid(ai_valid),
        .col_full(col_full),
        .drop_valid(drop_valid), .drop_col(drop_col), .drop_player(drop_player), .drop_ready(drop_ready),
        .chk_start(chk_start), .chk_done(chk_done), .chk_win(chk_win), .chk_draw(chk_draw),
        .new_game(new_game), .player(player), .game_over(game_over), .winner(winner),
        .moves(moves), .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        human_col = 3'd0; human_valid = 1'b0; ai_mode = 1'b0; ai_col = 3'd0; ai_valid = 1'b0;
        col_full = '0; drop_ready = 1'b0; chk_done = 1'b0; chk_win = 1'b0; chk_draw = 1'b0;
        new_game = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic human_request(input logic [2:0] c);
        human_col = c; human_valid = 1'b1;
        tick();
        human_valid = 1'b0;
    endtask

    task automatic complete_drop();
        drop_ready = 1'b1;
        tick();
        drop_ready = 1'b0;
    endtask

    task automatic finish_check(input logic win, input logic draw);
        chk_done = 1'b1; chk_win = win; chk_draw = draw;
        tick();
        chk_done = 1'b0; chk_win = 1'b0; chk_draw = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; human_valid = 1'b1; human_col = 3'd2;
        tick(); tick();
        rst = 1'b0; human_valid = 1'b0;
        total++; if ({drop_valid, drop_player, chk_start, ai_req, illegal, timeout, game_over, player} !== 8'h00) begin
            bad++; $display("FAIL reset_flags: got %b want 00000000",
                {drop_valid, drop_player, chk_start, ai_req, illegal, timeout, game_over, player});
        end
        total++; if (drop_col !== 3'd0) begin bad++; $display("FAIL reset_drop_col: got %0d want 0", drop_col); end
        total++; if (winner !== 2'b00)  begin bad++; $display("FAIL reset_winner: got %b want 00", winner); end
        total++; if (moves !== 6'd0)    begin bad++; $display("FAIL reset_moves: got %0d want 0", moves); end
    endtask

    task automatic test_human_move();
        human_request(3'd3);
        total++; if ({drop_valid, drop_col, drop_player} !== {1'b1, 3'd3, 1'b0}) begin
            bad++; $display("FAIL issue_first: got v=%b col=%0d p=%b want v=1 col=3 p=0", drop_valid, drop_col, drop_player);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if ({drop_valid, drop_col, drop_player} !== {1'b1, 3'd3, 1'b0}) begin
                bad++; $display("FAIL issue_hold%0d: got v=%b col=%0d p=%b want v=1 col=3 p=0", i, drop_valid, drop_col, drop_player);
            end
        end
        complete_drop();
        total++; if ({chk_start, moves} !== {1'b1, 6'd1}) begin
            bad++; $display("FAIL transfer: got chk_start=%b moves=%0d want 1 1", chk_start, moves);
        end
        total++; if ({drop_valid, drop_col} !== 4'b0) begin
            bad++; $display("FAIL drop_idle: got v=%b col=%0d want 0 0", drop_valid, drop_col);
        end
        tick();
        total++; if (chk_start !== 1'b0) begin bad++; $display("FAIL chk_start_pulse: got %b want 0", chk_start); end
        finish_check(1'b0, 1'b0);
        total++; if ({player, game_over} !== 2'b10) begin
            bad++; $display("FAIL pass_turn: got player=%b over=%b want 1 0", player, game_over);
        end
    endtask

    task automatic test_ai_turn();
        ai_mode = 1'b1;
        #1;
        total++; if (ai_req !== 1'b1) begin bad++; $display("FAIL ai_req_on: got %b want 1", ai_req); end
        human_request(3'd2);
        total++; if ({drop_valid, illegal, ai_req} !== 3'b001) begin
            bad++; $display("FAIL ai_ignores_human: got v=%b ill=%b req=%b want 0 0 1", drop_valid, illegal, ai_req);
        end
        ai_col = 3'd5; ai_valid = 1'b1;
        tick();
        ai_valid = 1'b0;
        total++; if ({drop_valid, drop_col, drop_player, ai_req} !== {1'b1, 3'd5, 1'b1, 1'b0}) begin
            bad++; $display("FAIL ai_move: got v=%b col=%0d p=%b req=%b want 1 5 1 0", drop_valid, drop_col, drop_player, ai_req);
        end
        complete_drop();
        finish_check(1'b0, 1'b0);
        total++; if ({player, moves, ai_req} !== {1'b0, 6'd2, 1'b0}) begin
            bad++; $display("FAIL ai_done: got p=%b moves=%0d req=%b want 0 2 0", player, moves, ai_req);
        end
        ai_col = 3'd1; ai_valid = 1'b1;
        tick();
        ai_valid = 1'b0; ai_mode = 1'b0;
        total++; if (drop_valid !== 1'b0) begin bad++; $display("FAIL human_ignores_ai: got %b want 0", drop_valid); end
    endtask

    task automatic test_illegal();
        do_reset();
        col_full = 7'b0001000;
        human_request(3'd3);
        total++; if ({illegal, drop_valid, game_over} !== 3'b100) begin
            bad++; $display("FAIL illegal_full: got ill=%b v=%b over=%b want 1 0 0", illegal, drop_valid, game_over);
        end
        tick();
        total++; if ({illegal, drop_valid} !== 2'b00) begin
            bad++; $display("FAIL illegal_pulse: got ill=%b v=%b want 0 0", illegal, drop_valid);
        end
        human_request(3'd7);
        total++; if ({illegal, drop_valid} !== 2'b10) begin
            bad++; $display("FAIL illegal_range: got ill=%b v=%b want 1 0", illegal, drop_valid);
        end
        col_full = '0;
    endtask

    task automatic test_win_over();
        do_reset();
        human_request(3'd0);
        complete_drop();
        finish_check(1'b1, 1'b1);
        total++; if ({game_over, winner, moves} !== {1'b1, 2'b01, 6'd1}) begin
            bad++; $display("FAIL win_p0: got over=%b w=%b moves=%0d want 1 01 1", game_over, winner, moves);
        end
        human_valid = 1'b1; human_col = 3'd1; ai_valid = 1'b1; ai_col = 3'd2;
        drop_ready = 1'b1; chk_done = 1'b1; chk_draw = 1'b1;
        tick(); tick(); tick();
        idle_inputs();
        total++; if ({game_over, winner, moves, drop_valid, chk_start} !== {1'b1, 2'b01, 6'd1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL over_ignores: got over=%b w=%b moves=%0d v=%b cs=%b want 1 01 1 0 0",
                game_over, winner, moves, drop_valid, chk_start);
        end
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        total++; if ({player, winner, moves, game_over, drop_valid, chk_start, ai_req} !== 13'b0) begin
            bad++; $display("FAIL new_game: got p=%b w=%b moves=%0d over=%b v=%b cs=%b req=%b want all 0",
                player, winner, moves, game_over, drop_valid, chk_start, ai_req);
        end
    endtask

    task automatic test_rst_abort();
        do_reset();
        human_request(3'd4);
        total++; if (drop_valid !== 1'b1) begin bad++; $display("FAIL abort_setup: got %b want 1", drop_valid); end
        rst = 1'b1; drop_ready = 1'b1;
        tick();
        rst = 1'b0; drop_ready = 1'b0;
        total++; if ({drop_valid, drop_col, drop_player, chk_start, moves, game_over, illegal, timeout} !== 14'b0) begin
            bad++; $display("FAIL rst_in_issue: got v=%b col=%0d p=%b cs=%b moves=%0d over=%b ill=%b to=%b want all 0",
                drop_valid, drop_col, drop_player, chk_start, moves, game_over, illegal, timeout);
        end
        human_request(3'd4);
        complete_drop();
        rst = 1'b1; chk_done = 1'b1; chk_win = 1'b1;
        tick();
        idle_inputs(); rst = 1'b0;
        total++; if ({moves, chk_start, game_over, winner} !== 10'b0) begin
            bad++; $display("FAIL rst_in_check: got moves=%0d cs=%b over=%b w=%b want 0 0 0 00", moves, chk_start, game_over, winner);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
`ifdef TURN_TIMEOUT_EN
        col_full = 7'b0000011;
        n = 0;
        while (timeout !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        total++; if (n != TIMEOUT_CYCLES) begin bad++; $display("FAIL timeout_delay: got %0d want %0d", n, TIMEOUT_CYCLES); end
        total++; if ({drop_valid, drop_col, drop_player} !== {1'b1, 3'd2, 1'b0}) begin
            bad++; $display("FAIL timeout_move: got v=%b col=%0d p=%b want 1 2 0", drop_valid, drop_col, drop_player);
        end
        tick();
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_pulse: got %b want 0", timeout); end
        complete_drop();
        finish_check(1'b0, 1'b0);
        ai_mode = 1'b1;
        n = 0;
        while (timeout !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        total++; if ({timeout, ai_req, drop_player, drop_col} !== {1'b1, 1'b0, 1'b1, 3'd2}) begin
            bad++; $display("FAIL timeout_ai: got to=%b req=%b p=%b col=%0d want 1 0 1 2", timeout, ai_req, drop_player, drop_col);
        end
        idle_inputs();
`else
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (timeout !== 1'b0 || drop_valid !== 1'b0) n++;
        end
        total++; if (n != 0) begin bad++; $display("FAIL no_timer: got %0d active cycles want 0", n); end
`endif
    endtask

    // Random games checked against a game-level model: turn owner, move count and result.
    task automatic test_random_games();
        logic       m_player;
        logic       m_over;
        logic [1:0] m_winner;
        int         m_moves;
        logic [6:0] fulls;
        int         col;
        logic       legal;
        logic       by_ai;
        logic       win;
        logic       draw;
        int         r;
        do_reset();
        for (int g = 0; g < 6; g++) begin
            new_game = 1'b1;
            tick();
            new_game = 1'b0;
            m_player = 1'b0; m_over = 1'b0; m_winner = 2'b00; m_moves = 0;
            total++; if ({player, winner, moves} !== 9'b0) begin
                bad++; $display("FAIL rnd_new_game g%0d: got p=%b w=%b moves=%0d want 0", g, player, winner, moves);
            end
            for (int t = 0; t < 45 && !m_over; t++) begin
                ai_mode = 1'($urandom_range(0, 1));
                by_ai = m_player & ai_mode;
                #1;
                total++; if (ai_req !== by_ai) begin bad++; $display("FAIL rnd_ai_req: got %b want %b", ai_req, by_ai); end
                for (int k = 0; k < 5; k++) begin
                    fulls = 7'($urandom);
                    if (fulls == 7'h7f) fulls = 7'h7e;
                    col = $urandom_range(0, 7);
                    if (k == 4) begin
                        col = 0;
                        while (fulls[col]) col++;
                    end
                    legal = (col < NUM_COLS) ? !fulls[col] : 1'b0;
                    col_full = fulls;
                    if (by_ai) begin
                        ai_valid = 1'b1; ai_col = 3'(col);
                        human_valid = 1'($urandom_range(0, 1)); human_col = 3'($urandom);
                    end else begin
                        human_valid = 1'b1; human_col = 3'(col);
                        ai_valid = 1'($urandom_range(0, 1)); ai_col = 3'($urandom);
                    end
                    tick();
                    ai_valid = 1'b0; human_valid = 1'b0;
                    if (!legal) begin
                        total++; if ({illegal, drop_valid} !== 2'b10) begin
                            bad++; $display("FAIL rnd_illegal col=%0d: got ill=%b v=%b want 1 0", col, illegal, drop_valid);
                        end
                    end else begin
                        total++; if ({drop_valid, drop_col, drop_player, illegal} !== {1'b1, 3'(col), m_player, 1'b0}) begin
                            bad++; $display("FAIL rnd_drop: got v=%b col=%0d p=%b ill=%b want 1 %0d %b 0",
                                drop_valid, drop_col, drop_player, illegal, col, m_player);
                        end
                        break;
                    end
                end
                r = $urandom_range(0, 3);
                for (int w = 0; w < r; w++) tick();
                complete_drop();
                m_moves = (m_moves < 42) ? m_moves + 1 : 42;
                total++; if ({chk_start, moves} !== {1'b1, 6'(m_moves)}) begin
                    bad++; $display("FAIL rnd_transfer: got cs=%b moves=%0d want 1 %0d", chk_start, moves, m_moves);
                end
                r = $urandom_range(0, 2);
                for (int w = 0; w < r; w++) tick();
                r = $urandom_range(0, 15);
                win  = (g != 0) && (r <= 2);
                draw = (g != 0) && (r == 0 || r == 3 || (win && r == 1));
                finish_check(win, draw);
                if (win) begin
                    m_over = 1'b1; m_winner = m_player ? 2'b10 : 2'b01;
                end else if (draw) begin
                    m_over = 1'b1; m_winner = 2'b11;
                end else begin
                    m_player = ~m_player;
                end
                total++; if ({game_over, winner, player} !== {m_over, m_winner, m_player}) begin
                    bad++; $display("FAIL rnd_result: got over=%b w=%b p=%b want %b %b %b",
                        game_over, winner, player, m_over, m_winner, m_player);
                end
            end
            if (m_over) begin
                col_full = '0; human_valid = 1'b1; human_col = 3'd1; ai_valid = 1'b1; ai_col = 3'd1;
                tick();
                idle_inputs();
                total++; if ({drop_valid, game_over} !== 2'b01) begin
                    bad++; $display("FAIL rnd_over_hold: got v=%b over=%b want 0 1", drop_valid, game_over);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_human_move();
        test_ai_turn();
        test_illegal();
        test_win_over();
        test_rst_abort();
        test_timeout();
        test_random_games();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
